// File: rtl/fetch_stall_ctrl_pkg.sv
// Shared front-end definitions for the 5-stage MIPS pipeline: fetch FSM
// states and the instruction/PC constants used by the fetch stall controller.
package fetch_stall_ctrl_pkg;

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        HALTED   = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_stall_ctrl_sat_counter.sv
// Saturating up-counter: counts Inc cycles and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] MAX = {W{1'b1}};

    logic [W-1:0] r_count;

    // Event counter, frozen once it reaches the maximum value.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
        end else if (Inc && (r_count != MAX)) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign Count = r_count;

endmodule

// File: rtl/fetch_stall_ctrl.sv
// Front-end controller: owns the PC and IF/ID register, honours load-use
// stalls, branch redirects and halt, and counts stall/flush events.
module fetch_stall_ctrl
    import fetch_stall_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             HDU_Stall,
    input  logic             HDU_Bubble,
    input  logic             Branch_Taken,
    input  logic [31:0]      Branch_Target,
    input  logic             Halt,
    input  logic [31:0]      Imem_Data,
    output logic [31:0]      Imem_Addr,
    output logic [31:0]      IFID_Instruction,
    output logic [31:0]      IFID_PCPlus4,
    output logic             IFID_Valid,
    output logic             Ctrl_Bubble,
    output logic [CNT_W-1:0] Stall_Count,
    output logic [CNT_W-1:0] Flush_Count
);

    fetch_state_t r_state;
    fetch_state_t w_next_state;

    logic [31:0] r_pc;
    logic [31:0] r_ifid_instr;
    logic [31:0] r_ifid_pcplus4;
    logic        r_ifid_valid;

    logic        w_stall;
    logic        w_flush;
    logic        w_advance;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_target;

    // Per-cycle action decode; branch and halt only count when not stalled.
    always_comb begin
        w_stall    = 1'b0;
        w_flush    = 1'b0;
        w_advance  = 1'b0;
        w_pc_plus4 = r_pc + PC_INC;
        w_target   = Branch_Target & ~32'h0000_0003;
        if (r_state == RUN) begin
            w_stall   = HDU_Stall;
            w_flush   = !HDU_Stall && Branch_Taken;
            w_advance = !HDU_Stall && !Branch_Taken;
        end else begin
            w_stall   = 1'b0;
            w_flush   = 1'b0;
            w_advance = 1'b0;
        end
    end

    // FSM next-state logic; HALTED is left only through Reset.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            RST_HOLD: w_next_state = RUN;
            RUN: begin
                if (Halt && !HDU_Stall) begin
                    w_next_state = HALTED;
                end else begin
                    w_next_state = RUN;
                end
            end
            HALTED:   w_next_state = HALTED;
            default:  w_next_state = HALTED;
        endcase
    end

    // FSM state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= RST_HOLD;
        end else begin
            r_state <= w_next_state;
        end
    end

    // PC and IF/ID register: advance, redirect with a NOP, or hold.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pc           <= RESET_PC;
            r_ifid_instr   <= NOP_INSTR;
            r_ifid_pcplus4 <= 32'h0000_0000;
            r_ifid_valid   <= 1'b0;
        end else if (w_advance) begin
            r_pc           <= w_pc_plus4;
            r_ifid_instr   <= Imem_Data;
            r_ifid_pcplus4 <= w_pc_plus4;
            r_ifid_valid   <= 1'b1;
        end else if (w_flush) begin
            r_pc           <= w_target;
            r_ifid_instr   <= NOP_INSTR;
            r_ifid_pcplus4 <= 32'h0000_0000;
            r_ifid_valid   <= 1'b0;
        end else if (r_state == HALTED) begin
            r_pc           <= r_pc;
            r_ifid_instr   <= NOP_INSTR;
            r_ifid_pcplus4 <= 32'h0000_0000;
            r_ifid_valid   <= 1'b0;
        end else begin
            r_pc           <= r_pc;
            r_ifid_instr   <= r_ifid_instr;
            r_ifid_pcplus4 <= r_ifid_pcplus4;
            r_ifid_valid   <= r_ifid_valid;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (w_stall),
        .Count (Stall_Count)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .Clk   (Clk),
        .Reset (Reset),
        .Inc   (w_flush),
        .Count (Flush_Count)
    );

    assign Imem_Addr        = r_pc;
    assign IFID_Instruction = r_ifid_instr;
    assign IFID_PCPlus4     = r_ifid_pcplus4;
    assign IFID_Valid       = r_ifid_valid;
    assign Ctrl_Bubble      = HDU_Bubble || (r_state != RUN);

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Bench for fetch_stall_ctrl: directed scenarios then random stimulus, all
// checked against a cycle-level behavioural model of the front end.
module tb_fetch_stall_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        HDU_Stall = 1'b0;
    logic        HDU_Bubble = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [31:0] Branch_Target = 32'h0;
    logic        Halt = 1'b0;

    logic [31:0] Imem_Data, Imem_Addr, IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid, Ctrl_Bubble;
    logic [31:0] Stall_Count, Flush_Count;

    logic [31:0] Imem_Data4, Imem_Addr4, IFID_Instruction4, IFID_PCPlus44;
    logic        IFID_Valid4, Ctrl_Bubble4;
    logic [3:0]  Stall_Count4, Flush_Count4;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] imem(input logic [31:0] a);
        if (a == 32'h0) return 32'h2010_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    assign Imem_Data  = imem(Imem_Addr);
    assign Imem_Data4 = imem(Imem_Addr4);

    fetch_stall_ctrl #(.RESET_PC(32'h0), .CNT_W(32)) dut (
        .Clk(Clk), .Reset(Reset), .HDU_Stall(HDU_Stall), .HDU_Bubble(HDU_Bubble),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target), .Halt(Halt),
        .Imem_Data(Imem_Data), .Imem_Addr(Imem_Addr), .IFID_Instruction(IFID_Instruction),
        .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid), .Ctrl_Bubble(Ctrl_Bubble),
        .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
    );

    fetch_stall_ctrl #(.RESET_PC(32'h0), .CNT_W(4)) dut4 (
        .Clk(Clk), .Reset(Reset), .HDU_Stall(HDU_Stall), .HDU_Bubble(HDU_Bubble),
        .Branch_Taken(Branch_Taken), .Branch_Target(Branch_Target), .Halt(Halt),
        .Imem_Data(Imem_Data4), .Imem_Addr(Imem_Addr4), .IFID_Instruction(IFID_Instruction4),
        .IFID_PCPlus4(IFID_PCPlus44), .IFID_Valid(IFID_Valid4), .Ctrl_Bubble(Ctrl_Bubble4),
        .Stall_Count(Stall_Count4), .Flush_Count(Flush_Count4)
    );

    // Behavioural model: phase 0 = post-reset hold, 1 = fetching, 2 = halted.
    logic [31:0] m_pc, m_instr, m_pc4, m_sc, m_fc;
    logic        m_valid;
    logic [3:0]  m_sc4, m_fc4;
    int          m_phase;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
        m_sc = 32'h0; m_fc = 32'h0; m_sc4 = 4'h0; m_fc4 = 4'h0; m_phase = 0;
    endtask

    task automatic check_all();
        chk("pc", Imem_Addr, m_pc);
        chk("valid", {31'h0, IFID_Valid}, {31'h0, m_valid});
        chk("instr", IFID_Instruction, m_instr);
        if (m_valid) chk("pcplus4", IFID_PCPlus4, m_pc4);
        chk("bubble", {31'h0, Ctrl_Bubble}, {31'h0, (HDU_Bubble || m_phase != 1)});
        chk("stall_cnt", Stall_Count, m_sc);
        chk("flush_cnt", Flush_Count, m_fc);
        chk("stall_cnt4", {28'h0, Stall_Count4}, {28'h0, m_sc4});
        chk("flush_cnt4", {28'h0, Flush_Count4}, {28'h0, m_fc4});
    endtask

    task automatic model_next(input logic rst, stall, br, input logic [31:0] tgt, input logic hlt);
        if (rst) begin
            model_reset();
        end else if (m_phase == 0) begin
            m_phase = 1;
        end else if (m_phase == 2) begin
            m_instr = 32'h0; m_valid = 1'b0;
        end else if (stall) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
            if (m_sc4 != 4'hF) m_sc4 = m_sc4 + 1;
        end else begin
            if (br) begin
                m_pc = {tgt[31:2], 2'b00};
                m_instr = 32'h0; m_valid = 1'b0;
                if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
                if (m_fc4 != 4'hF) m_fc4 = m_fc4 + 1;
            end else begin
                m_instr = imem(m_pc);
                m_pc = m_pc + 32'd4;
                m_pc4 = m_pc;
                m_valid = 1'b1;
            end
            if (hlt) m_phase = 2;
        end
    endtask

    task automatic step(input logic rst, stall, bub, br, input logic [31:0] tgt, input logic hlt);
        @(negedge Clk);
        Reset = rst; HDU_Stall = stall; HDU_Bubble = bub;
        Branch_Taken = br; Branch_Target = tgt; Halt = hlt;
        #1;
        check_all();
        @(posedge Clk);
        model_next(rst, stall, br, tgt, hlt);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge Clk);
        model_reset();
        #1;
        chk("rst_pc", Imem_Addr, 32'h0);
        chk("rst_valid", {31'h0, IFID_Valid}, 32'h0);
        chk("rst_stall_cnt", Stall_Count, 32'h0);

        // Release reset: one hold cycle, then the first fetch.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("hold_pc", Imem_Addr, 32'h0);
        chk("hold_valid", {31'h0, IFID_Valid}, 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("first_instr", IFID_Instruction, 32'h2010_0005);
        chk("first_pc4", IFID_PCPlus4, 32'h4);
        chk("first_pc", Imem_Addr, 32'h4);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Two stall cycles at PC=8.
        step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
        chk("stall_pc", Imem_Addr, 32'h8);
        chk("stall_cnt2", Stall_Count, 32'd2);
        chk("stall_flush0", Flush_Count, 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);

        // Taken branch at PC=12.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40, 1'b0);
        chk("br_pc", Imem_Addr, 32'h40);
        chk("br_valid", {31'h0, IFID_Valid}, 32'h0);
        chk("br_flush", Flush_Count, 32'd1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("br_tgt_pc4", IFID_PCPlus4, 32'h44);

        // Stall and branch together, then the branch alone.
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0);
        chk("sb_pc", Imem_Addr, 32'h44);
        chk("sb_flush", Flush_Count, 32'd1);
        chk("sb_stall", Stall_Count, 32'd3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0);
        chk("sb_redirect", Imem_Addr, 32'h80);

        // Misaligned target is forced to word alignment; PC+4 wraps.
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("align_pc", Imem_Addr, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("wrap_pc", Imem_Addr, 32'h0);
        chk("wrap_pc4", IFID_PCPlus4, 32'h0);

        // Halt freezes the front end until reset.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h200, 1'b0);
        chk("halt_pc", Imem_Addr, 32'h4);
        chk("halt_valid", {31'h0, IFID_Valid}, 32'h0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("halt_rst_pc", Imem_Addr, 32'h0);

        // Narrow counter saturation.
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("sat4", {28'h0, Stall_Count4}, 32'hF);
        chk("sat32", Stall_Count, 32'd20);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        chk("sat4_rst", {28'h0, Stall_Count4}, 32'h0);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(63) == 0), ($urandom_range(3) == 0), $urandom_range(1),
                 ($urandom_range(5) == 0), $urandom, ($urandom_range(49) == 0));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
